// File: rtl/spi_target_if.sv
// spi_target_if: Wishbone register bus between a host and spi_target
interface spi_target_if;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic [31:0] dat_o;
    modport master (output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, input ack_o, dat_o);
    modport slave  (input adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, output ack_o, dat_o);
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with a Wishbone TX register, RX FIFO and status/irq
module spi_target #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_target_if.slave bus,
    input  logic        spi_clk_i,
    input  logic        spi_cs_i,
    input  logic        spi_data_i,
    output logic        spi_data_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    logic [2:0] sck_q, cs_q;
    logic [1:0] mosi_q, settle;
    logic armed;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh, tx_data;
    logic tx_pending, overflow;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic cs_low, sck_rise, sck_fall, cs_fall, byte_done, acc, empty, full;
    logic pop, push, drop, wr_tx, clr_ovf, load;
    logic [1:0] reg_sel;
    logic [4:0] status;
    logic [31:0] rdata;
    logic unused;
    // armed stays low after reset until CS is seen high, so a frame cut by reset is ignored
    assign cs_low = ~cs_q[1];
    assign sck_rise = armed & cs_low & sck_q[1] & ~sck_q[2];
    assign sck_fall = armed & cs_low & ~sck_q[1] & sck_q[2];
    assign cs_fall = armed & cs_q[2] & ~cs_q[1];
    assign byte_done = sck_rise & (bit_cnt == 3'd7);
    assign acc = bus.stb_i & bus.cyc_i & ~bus.ack_o;
    assign reg_sel = bus.adr_i[3:2];
    assign empty = count == '0;
    assign full = count == FULL_CNT;
    assign pop = acc & ~bus.we_i & (reg_sel == 2'd0) & ~empty;
    assign push = byte_done & (~full | pop);
    assign drop = byte_done & full & ~pop;
    assign wr_tx = acc & bus.we_i & (reg_sel == 2'd0);
    assign clr_ovf = acc & bus.we_i & (reg_sel == 2'd1) & bus.dat_i[2];
    assign load = cs_fall | byte_done;
    assign status = {cs_low, tx_pending, overflow, full, empty};
    assign rdata = reg_sel == 2'd0 ? (empty ? 32'd0 : {24'd0, mem[rp]}) :
                   reg_sel == 2'd1 ? {27'd0, status} : 32'd0;
    assign spi_data_o = cs_low & tx_sh[7];
    assign irq_o = ~empty | overflow;
    assign unused = ^{bus.sel_i, bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:8]};
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {rx_sh[6:0], mosi_q[1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 3'b000;
            cs_q <= 3'b111;
            mosi_q <= 2'b00;
            settle <= 2'b00;
            armed <= 1'b0;
            bit_cnt <= 3'd0;
            rx_sh <= 8'd0;
            tx_sh <= 8'hFF;
            tx_data <= 8'd0;
            tx_pending <= 1'b0;
            overflow <= 1'b0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            bus.ack_o <= 1'b0;
            bus.dat_o <= 32'd0;
        end else begin
            sck_q <= {sck_q[1:0], spi_clk_i};
            cs_q <= {cs_q[1:0], spi_cs_i};
            mosi_q <= {mosi_q[0], spi_data_i};
            settle <= {settle[0], 1'b1};
            armed <= armed | (settle[1] & ~cs_low);
            if (cs_fall || !cs_low) bit_cnt <= 3'd0;
            else if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
            if (sck_rise) rx_sh <= {rx_sh[6:0], mosi_q[1]};
            // the falling edge right after a byte boundary must not shift the freshly loaded byte
            if (load) tx_sh <= tx_pending ? tx_data : 8'hFF;
            else if (sck_fall && bit_cnt != 3'd0) tx_sh <= {tx_sh[6:0], 1'b1};
            tx_pending <= wr_tx | (tx_pending & ~load);
            if (wr_tx) tx_data <= bus.dat_i[7:0];
            overflow <= drop | (overflow & ~clr_ovf);
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            bus.ack_o <= acc;
            bus.dat_o <= (acc & ~bus.we_i) ? rdata : 32'd0;
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed, table-driven and randomized checks of spi_target against a queue model
module tb_spi_target;
    logic clk, rst_n, spi_clk_i, spi_cs_i, spi_data_i, spi_data_o, irq_o;
    int n_chk = 0, n_fail = 0;
    spi_target_if bus();
    spi_target #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_clk_i(spi_clk_i), .spi_cs_i(spi_cs_i), .spi_data_i(spi_data_i),
        .spi_data_o(spi_data_o), .irq_o(irq_o)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        bus.adr_i = {28'h0, a, 2'b00};
        bus.dat_i = d;
        bus.we_i = we;
        bus.sel_i = 4'hF;
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        @(negedge clk);
        chk("ack", {31'd0, bus.ack_o}, 32'd1);
        r = bus.dat_o;
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.we_i = 1'b0;
        @(negedge clk);
        chk("ack_low", {31'd0, bus.ack_o}, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] r;
        bus_xfer(1'b0, a, 32'd0, r);
        chk(nm, r, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(1'b1, a, d, r);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_data_i = b;
        repeat (4) @(negedge clk);
        spi_clk_i = 1'b1;
        m = spi_data_o;
        repeat (4) @(negedge clk);
        spi_clk_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], t);
            m[i] = t;
        end
    endtask

    task automatic cs_on();
        @(negedge clk);
        spi_cs_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (4) @(negedge clk);
        spi_cs_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, output logic [7:0] m);
        cs_on();
        spi_byte(b, m);
        cs_off();
    endtask

    // the DATA read is timed to land on the same clock as the 8th rising edge after synchronization
    task automatic frame_with_read(input logic [7:0] b, output logic [31:0] r);
        logic t;
        cs_on();
        for (int i = 7; i >= 1; i--) spi_bit(b[i], t);
        spi_data_i = b[0];
        repeat (4) @(negedge clk);
        spi_clk_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.adr_i = 32'h0;
        bus.we_i = 1'b0;
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        @(negedge clk);
        chk("coinc_ack", {31'd0, bus.ack_o}, 32'd1);
        r = bus.dat_o;
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        @(negedge clk);
        spi_clk_i = 1'b0;
        cs_off();
    endtask

    // reference model
    logic [7:0] mq[$];
    logic m_ovf, m_pend;
    logic [7:0] m_tx;

    function automatic logic [31:0] m_status();
        return {27'd0, 1'b0, m_pend, m_ovf, mq.size() == 4, mq.size() == 0};
    endfunction

    initial begin
        vec_t vt[12];
        logic [7:0] m;
        logic [31:0] r;
        rst_n = 1'b0;
        spi_cs_i = 1'b1;
        spi_clk_i = 1'b0;
        spi_data_i = 1'b0;
        bus.adr_i = 32'd0;
        bus.dat_i = 32'd0;
        bus.we_i = 1'b0;
        bus.sel_i = 4'h0;
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        chk("rst_dat", bus.dat_o, 32'd0);
        chk("rst_miso", {31'd0, spi_data_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(2'd1, 32'h1, "status_after_reset");

        frame(8'h55, m);
        chk("idle_miso_ff", {24'd0, m}, 32'hFF);
        rd(2'd1, 32'h0, "status_no_pend");
        rd(2'd0, 32'h55, "data_55");

        wr(2'd0, 32'hA5);
        rd(2'd1, 32'h9, "status_pend");
        frame(8'h3C, m);
        chk("miso_a5", {24'd0, m}, 32'hA5);
        rd(2'd1, 32'h0, "status_rx");
        chk("irq_rx", {31'd0, irq_o}, 32'd1);
        rd(2'd0, 32'h3C, "data_3c");
        rd(2'd1, 32'h1, "status_empty");

        for (int i = 1; i <= 5; i++) begin
            frame(8'(i), m);
            chk("fill_miso", {24'd0, m}, 32'hFF);
        end
        chk("irq_ovf", {31'd0, irq_o}, 32'd1);
        vt[0]  = '{1'b0, 2'd1, 32'd0, 32'h6};
        vt[1]  = '{1'b0, 2'd0, 32'd0, 32'h1};
        vt[2]  = '{1'b0, 2'd0, 32'd0, 32'h2};
        vt[3]  = '{1'b0, 2'd0, 32'd0, 32'h3};
        vt[4]  = '{1'b0, 2'd0, 32'd0, 32'h4};
        vt[5]  = '{1'b0, 2'd0, 32'd0, 32'h0};
        vt[6]  = '{1'b0, 2'd1, 32'd0, 32'h5};
        vt[7]  = '{1'b1, 2'd1, 32'h4, 32'h0};
        vt[8]  = '{1'b0, 2'd1, 32'd0, 32'h1};
        vt[9]  = '{1'b1, 2'd2, 32'hDEAD, 32'h0};
        vt[10] = '{1'b0, 2'd2, 32'd0, 32'h0};
        vt[11] = '{1'b0, 2'd3, 32'd0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            bus_xfer(vt[i].we, vt[i].a, vt[i].d, r);
            if (!vt[i].we) chk($sformatf("vec%0d", i), r, vt[i].exp);
        end
        chk("irq_cleared", {31'd0, irq_o}, 32'd0);

        cs_on();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m[0]);
        cs_off();
        frame(8'h81, m);
        rd(2'd0, 32'h81, "partial_then_81");
        rd(2'd0, 32'h0, "partial_only_one");

        frame(8'h11, m);
        frame(8'h22, m);
        frame(8'h33, m);
        frame(8'h44, m);
        frame_with_read(8'h99, r);
        chk("coinc_pop", r, 32'h11);
        rd(2'd1, 32'h2, "coinc_status");
        rd(2'd0, 32'h22, "coinc_r1");
        rd(2'd0, 32'h33, "coinc_r2");
        rd(2'd0, 32'h44, "coinc_r3");
        rd(2'd0, 32'h99, "coinc_new_last");

        wr(2'd0, 32'h12);
        cs_on();
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m[0]);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_irq", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) spi_bit(1'b1, m[0]);
        cs_off();
        rd(2'd1, 32'h1, "midrst_ignored");
        frame(8'h5A, m);
        chk("midrst_txdata_clr", {24'd0, m}, 32'hFF);
        rd(2'd0, 32'h5A, "midrst_next");

        m_ovf = 1'b0;
        m_pend = 1'b0;
        m_tx = 8'h0;
        for (int it = 0; it < 60; it++) begin
            int op;
            logic [31:0] d;
            op = $urandom_range(0, 5);
            d = $urandom;
            if (op == 0) begin
                wr(2'd0, d);
                m_pend = 1'b1;
                m_tx = d[7:0];
            end else if (op <= 2) begin
                int nb;
                nb = $urandom_range(1, 3);
                cs_on();
                for (int k = 0; k < nb; k++) begin
                    logic [7:0] b, e;
                    b = 8'($urandom);
                    e = m_pend ? m_tx : 8'hFF;
                    m_pend = 1'b0;
                    spi_byte(b, m);
                    chk("rnd_miso", {24'd0, m}, {24'd0, e});
                    if (mq.size() < 4) mq.push_back(b);
                    else m_ovf = 1'b1;
                end
                cs_off();
            end else if (op == 3) begin
                rd(2'd0, mq.size() ? {24'd0, mq.pop_front()} : 32'd0, "rnd_data");
            end else if (op == 4) begin
                rd(2'd1, m_status(), "rnd_status");
            end else begin
                wr(2'd1, d);
                if (d[2]) m_ovf = 1'b0;
            end
            chk("rnd_irq", {31'd0, irq_o}, {31'd0, (mq.size() != 0) | m_ovf});
        end
        rd(2'd1, m_status(), "rnd_final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
